// File: rtl/axil_data_master.sv
// rtl/axil_data_master.sv - AXI4-Lite master issuing one CPU load or store at a time
module axil_data_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam bit   TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t              state_q, state_d;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                arvalid_q, arvalid_d, rready_q, rready_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs, final_hs, timeout_hit;

    assign aw_hs    = awvalid_q & m_axi_awready;
    assign w_hs     = wvalid_q & m_axi_wready;
    assign b_hs     = bready_q & m_axi_bvalid;
    assign ar_hs    = arvalid_q & m_axi_arready;
    assign r_hs     = rready_q & m_axi_rvalid;
    // bready/rready are only ever high in their response states
    assign final_hs = b_hs | r_hs;
    assign timeout_hit = TO_EN && (state_q != IDLE) && (cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rdata_d       = rdata_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        cnt_d         = (state_q == IDLE) ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = req_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (m_axi_bresp != 2'b00);
                    state_d     = IDLE;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rdata_d     = m_axi_rdata;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (m_axi_rresp != 2'b00);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abandon the bus outright; a final handshake on the last cycle still wins
        if (timeout_hit && !final_hs) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            aw_done_d     = 1'b0;
            w_done_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= IDLE;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rdata_q       <= rdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ready     = (state_q == IDLE) && !areset;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_data_master.sv
// tb/tb_axil_data_master.sv - self-checking bench for axil_data_master
module tb_axil_data_master;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic areset;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    logic        h_req_valid, h_req_ready, h_req_write;
    logic [31:0] h_req_addr;
    logic [63:0] h_req_wdata, h_rsp_rdata, h_wdata, h_rdata;
    logic [7:0]  h_req_wstrb, h_wstrb;
    logic        h_rsp_valid, h_rsp_err, h_rsp_timeout;
    logic [31:0] h_awaddr, h_araddr;
    logic [2:0]  h_awprot, h_arprot;
    logic        h_awvalid, h_wvalid, h_bvalid, h_bready, h_arvalid, h_rvalid, h_rready;
    logic [1:0]  h_bresp, h_rresp;

    axil_data_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut32 (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    axil_data_master #(.ADDR_W(32), .DATA_W(64)) dut64 (
        .aclk(aclk), .areset(areset),
        .req_valid(h_req_valid), .req_ready(h_req_ready), .req_write(h_req_write),
        .req_addr(h_req_addr), .req_wdata(h_req_wdata), .req_wstrb(h_req_wstrb),
        .rsp_valid(h_rsp_valid), .rsp_rdata(h_rsp_rdata), .rsp_err(h_rsp_err),
        .rsp_timeout(h_rsp_timeout),
        .m_axi_awaddr(h_awaddr), .m_axi_awprot(h_awprot), .m_axi_awvalid(h_awvalid),
        .m_axi_awready(1'b1),
        .m_axi_wdata(h_wdata), .m_axi_wstrb(h_wstrb), .m_axi_wvalid(h_wvalid), .m_axi_wready(1'b1),
        .m_axi_bresp(h_bresp), .m_axi_bvalid(h_bvalid), .m_axi_bready(h_bready),
        .m_axi_araddr(h_araddr), .m_axi_arprot(h_arprot), .m_axi_arvalid(h_arvalid),
        .m_axi_arready(1'b1),
        .m_axi_rdata(h_rdata), .m_axi_rresp(h_rresp), .m_axi_rvalid(h_rvalid), .m_axi_rready(h_rready)
    );

    // zero-wait slave for the 64-bit instance: responds in the cycle the master is ready
    always @(negedge aclk) begin
        h_bvalid = h_bready;
        h_rvalid = h_rready;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_rdata;

    int          r_k, r_cnt, r_viol;
    logic        r_err, r_to, r_quiet, r_rdy_issue, r_rdy_rsp;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_wstrb;

    // final handshake cycle counted from accept; store needs both AW and W before B
    function automatic int model_final(bit wr, int aw_l, int w_l, int b_l, int ar_l, int r_l);
        if (wr) return ((aw_l > w_l) ? aw_l : w_l) + 1 + 1 + b_l;
        return 1 + ar_l + 1 + r_l;
    endfunction

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_l, input int w_l, input int b_l,
                           input int ar_l, input int r_l, input logic [1:0] resp,
                           input logic [31:0] rd, input bit hang);
        int aw_k = 0, w_k = 0, b_k = 0, ar_k = 0, r_k2 = 0;
        r_k = 0; r_cnt = 0; r_viol = 0; r_err = 0; r_to = 0; r_quiet = 0; r_rdy_rsp = 0;
        r_rdata = '0; r_addr = '0; r_wdata = '0; r_wstrb = '0;
        @(negedge aclk);
        r_rdy_issue = req_ready;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data; req_wstrb = strb;
        @(posedge aclk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge aclk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                r_cnt++;
                if (r_k == 0) begin
                    r_k = k; r_err = rsp_err; r_to = rsp_timeout; r_rdata = rsp_rdata;
                    r_rdy_rsp = req_ready;
                    r_quiet = !(awvalid | wvalid | bready | arvalid | rready);
                end
            end
            if (awvalid && aw_k != 0) r_viol++;
            if (wvalid && w_k != 0) r_viol++;
            if (arvalid && ar_k != 0) r_viol++;
            if (r_k == 0 && wr && ((aw_k == 0 && !awvalid) || (w_k == 0 && !wvalid))) r_viol++;
            if (r_k == 0 && !wr && ar_k == 0 && !arvalid) r_viol++;
            if (awvalid && awaddr !== addr) r_viol++;
            if (wvalid && (wdata !== data || wstrb !== strb)) r_viol++;
            if (arvalid && araddr !== addr) r_viol++;
            awready = awvalid && (k - 1 >= aw_l);
            wready  = wvalid && (k - 1 >= w_l);
            arready = arvalid && (k - 1 >= ar_l);
            if (awvalid && awready) begin aw_k = k; r_addr = awaddr; end
            if (wvalid && wready) begin w_k = k; r_wdata = wdata; r_wstrb = wstrb; end
            if (arvalid && arready) begin ar_k = k; r_addr = araddr; end
            bvalid = !hang && aw_k != 0 && w_k != 0 && b_k == 0 &&
                     k > ((aw_k > w_k) ? aw_k : w_k) + b_l;
            bresp = resp;
            if (bvalid && bready) b_k = k;
            rvalid = !hang && ar_k != 0 && r_k2 == 0 && k > ar_k + r_l;
            rresp = resp; rdata = rd;
            if (rvalid && rready) r_k2 = k;
            if (r_k != 0 && k >= r_k + 2) break;
        end
        @(negedge aclk);
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_timeout, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0", {rsp_valid, awvalid, wvalid, bready, arvalid, rready});
        end
        n_checks++;
        if ({awaddr, wdata, wstrb, araddr, rsp_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_payload: got %h %h %h %h %h want 0", awaddr, wdata, wstrb, araddr, rsp_rdata);
        end
        n_checks++;
        if ({awprot, arprot} !== 6'b0) begin n_fail++; $display("FAIL prot: got %b want 0", {awprot, arprot}); end
        areset = 1'b0;
        @(posedge aclk); @(negedge aclk);
        n_checks++;
        if (req_ready !== 1'b1 || h_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_ready: got %b%b want 11", req_ready, h_req_ready);
        end
        exp_rdata = '0;
    endtask

    task automatic test_store_zero_wait;
        run_txn(1, 32'h0001_0008, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
        n_checks++;
        if (r_rdy_issue !== 1'b1) begin n_fail++; $display("FAIL st0_ready: got %b want 1", r_rdy_issue); end
        n_checks++;
        if (r_k !== 3 || r_cnt !== 1) begin n_fail++; $display("FAIL st0_latency: got cyc %0d cnt %0d want 3 1", r_k, r_cnt); end
        n_checks++;
        if ({r_addr, r_wdata, r_wstrb} !== {32'h0001_0008, 32'hDEAD_BEEF, 4'b0011}) begin
            n_fail++; $display("FAIL st0_payload: got %h %h %b want 00010008 deadbeef 0011", r_addr, r_wdata, r_wstrb);
        end
        n_checks++;
        if ({r_err, r_to, r_rdy_rsp, r_viol} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin
            n_fail++; $display("FAIL st0_rsp: got err %b to %b rdy %b viol %0d want 0 0 1 0", r_err, r_to, r_rdy_rsp, r_viol);
        end
    endtask

    task automatic test_store_w_before_aw;
        run_txn(1, 32'h0000_0100, 32'hA5A5_0001, 4'b0000, 4, 0, 0, 0, 0, 2'b00, 32'h0, 0);
        n_checks++;
        if (r_viol !== 0) begin n_fail++; $display("FAIL split_protocol: got %0d violations want 0", r_viol); end
        n_checks++;
        if (r_k !== model_final(1, 4, 0, 0, 0, 0) + 1 || r_cnt !== 1) begin
            n_fail++; $display("FAIL split_rsp: got cyc %0d cnt %0d want 7 1", r_k, r_cnt);
        end
        n_checks++;
        if (r_wstrb !== 4'b0000 || r_err !== 1'b0) begin
            n_fail++; $display("FAIL split_zero_strb: got %b err %b want 0000 0", r_wstrb, r_err);
        end
    endtask

    task automatic test_load_err;
        run_txn(0, 32'h0000_2000, 32'h0, 4'h0, 0, 0, 0, 0, 3, 2'b10, 32'h1234_5678, 0);
        exp_rdata = 32'h1234_5678;
        n_checks++;
        if (r_k !== 6 || r_cnt !== 1) begin n_fail++; $display("FAIL ld_err_latency: got %0d %0d want 6 1", r_k, r_cnt); end
        n_checks++;
        if ({r_rdata, r_err, r_to} !== {exp_rdata, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL ld_err_rsp: got %h err %b to %b want 12345678 1 0", r_rdata, r_err, r_to);
        end
        n_checks++;
        if (r_addr !== 32'h0000_2000 || r_viol !== 0) begin
            n_fail++; $display("FAIL ld_err_addr: got %h viol %0d want 00002000 0", r_addr, r_viol);
        end
    endtask

    task automatic test_timeout;
        run_txn(1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1);
        n_checks++;
        if (r_k !== 17 || r_cnt !== 1) begin n_fail++; $display("FAIL to_cycle: got %0d cnt %0d want 17 1", r_k, r_cnt); end
        n_checks++;
        if ({r_err, r_to, r_quiet, r_rdy_rsp} !== 4'b1111) begin
            n_fail++; $display("FAIL to_flags: got %b want 1111", {r_err, r_to, r_quiet, r_rdy_rsp});
        end
        n_checks++;
        if (r_rdata !== exp_rdata) begin n_fail++; $display("FAIL to_rdata_hold: got %h want %h", r_rdata, exp_rdata); end
        run_txn(0, 32'h0000_0080, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFE_0080, 0);
        exp_rdata = 32'hCAFE_0080;
        n_checks++;
        if ({r_k, r_rdata, r_err, r_to} !== {32'd3, exp_rdata, 2'b00}) begin
            n_fail++; $display("FAIL to_recover: got cyc %0d %h err %b to %b want 3 %h 0 0", r_k, r_rdata, r_err, r_to, exp_rdata);
        end
    endtask

    task automatic test_timeout_boundary;
        run_txn(0, 32'h0000_00C0, 32'h0, 4'h0, 0, 0, 0, 0, 14, 2'b00, 32'h5555_AAAA, 0);
        exp_rdata = 32'h5555_AAAA;
        n_checks++;
        if ({r_k, r_rdata, r_err, r_to} !== {32'd17, exp_rdata, 2'b00}) begin
            n_fail++; $display("FAIL edge_hs_wins: got cyc %0d %h err %b to %b want 17 %h 0 0", r_k, r_rdata, r_err, r_to, exp_rdata);
        end
        run_txn(0, 32'h0000_00C4, 32'h0, 4'h0, 0, 0, 0, 0, 15, 2'b00, 32'h7777_0000, 0);
        n_checks++;
        if ({r_k, r_rdata, r_err, r_to} !== {32'd17, exp_rdata, 2'b11}) begin
            n_fail++; $display("FAIL edge_timeout: got cyc %0d %h err %b to %b want 17 %h 1 1", r_k, r_rdata, r_err, r_to, exp_rdata);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            bit          wr   = 1'($urandom);
            logic [31:0] addr = $urandom & 32'hFFFF_FFFC;
            logic [31:0] data = $urandom;
            logic [31:0] rd   = $urandom;
            logic [3:0]  strb = 4'($urandom);
            logic [1:0]  resp = 2'($urandom);
            int aw_l = $urandom_range(0, 3), w_l = $urandom_range(0, 3);
            int b_l  = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 3);
            int ar_l = $urandom_range(0, 3);
            int r_l  = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 3);
            int fin  = model_final(wr, aw_l, w_l, b_l, ar_l, r_l);
            bit to   = (fin > 16);
            run_txn(wr, addr, data, strb, aw_l, w_l, b_l, ar_l, r_l, resp, rd, 0);
            if (!wr && !to) exp_rdata = rd;
            n_checks++;
            if (r_k !== (to ? 17 : fin + 1) || r_cnt !== 1) begin
                n_fail++; $display("FAIL rnd%0d_cycle: got %0d cnt %0d want %0d 1", i, r_k, r_cnt, to ? 17 : fin + 1);
            end
            n_checks++;
            if ({r_err, r_to} !== {to || (resp != 2'b00), to}) begin
                n_fail++; $display("FAIL rnd%0d_status: got err %b to %b want %b %b", i, r_err, r_to, to || (resp != 0), to);
            end
            n_checks++;
            if (r_rdata !== exp_rdata || r_addr !== addr || r_viol !== 0) begin
                n_fail++; $display("FAIL rnd%0d_data: got %h %h viol %0d want %h %h 0", i, r_rdata, r_addr, r_viol, exp_rdata, addr);
            end
            if (wr) begin
                n_checks++;
                if ({r_wdata, r_wstrb} !== {data, strb}) begin
                    n_fail++; $display("FAIL rnd%0d_wpayload: got %h %b want %h %b", i, r_wdata, r_wstrb, data, strb);
                end
            end
        end
    endtask

    task automatic test_reset_midflight;
        bit seen = 0;
        @(negedge aclk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0300;
        @(posedge aclk); @(negedge aclk);
        req_valid = 1'b0; arready = 1'b1;
        @(posedge aclk); @(negedge aclk);
        arready = 1'b0;
        seen = seen | rsp_valid;
        n_checks++;
        if (rready !== 1'b1) begin n_fail++; $display("FAIL mid_rd_data: got rready %b want 1", rready); end
        @(posedge aclk); @(negedge aclk);
        seen = seen | rsp_valid;
        areset = 1'b1;
        @(posedge aclk); @(negedge aclk);
        seen = seen | rsp_valid;
        n_checks++;
        if ({req_ready, rready, arvalid, araddr, rsp_rdata, rsp_err} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %b %b %b %h %h want all 0", req_ready, rready, arvalid, araddr, rsp_rdata);
        end
        areset = 1'b0;
        @(posedge aclk); @(negedge aclk);
        seen = seen | rsp_valid;
        n_checks++;
        if (req_ready !== 1'b1 || seen !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_recover: got ready %b rsp_seen %b want 1 0", req_ready, seen);
        end
        exp_rdata = '0;
    endtask

    task automatic test_wide_b2b;
        logic [63:0] rd64 = {$urandom, $urandom};
        logic [63:0] wd64 = {$urandom, $urandom};
        int k = 0;
        h_rdata = rd64;
        @(negedge aclk);
        h_req_valid = 1'b1; h_req_write = 1'b0; h_req_addr = 32'h0000_1000;
        @(posedge aclk); @(negedge aclk);
        h_req_valid = 1'b0; k = 1;
        while (!h_rsp_valid && k < 20) begin @(posedge aclk); @(negedge aclk); k++; end
        n_checks++;
        if ({k, h_rsp_rdata, h_rsp_err, h_req_ready} !== {32'd3, rd64, 2'b01}) begin
            n_fail++; $display("FAIL wide_load: got cyc %0d %h err %b rdy %b want 3 %h 0 1", k, h_rsp_rdata, h_rsp_err, h_req_ready, rd64);
        end
        h_req_valid = 1'b1; h_req_write = 1'b1; h_req_addr = 32'h0000_2008;
        h_req_wdata = wd64; h_req_wstrb = 8'hA5;
        @(posedge aclk); @(negedge aclk);
        h_req_valid = 1'b0; k = 1;
        n_checks++;
        if ({h_awvalid, h_wvalid, h_awaddr, h_wdata, h_wstrb} !== {2'b11, 32'h0000_2008, wd64, 8'hA5}) begin
            n_fail++; $display("FAIL wide_store_issue: got %b%b %h %h %h want 11 00002008 %h a5", h_awvalid, h_wvalid, h_awaddr, h_wdata, h_wstrb, wd64);
        end
        while (!h_rsp_valid && k < 20) begin @(posedge aclk); @(negedge aclk); k++; end
        n_checks++;
        if ({k, h_rsp_err, h_rsp_timeout, h_rsp_rdata} !== {32'd3, 2'b00, rd64}) begin
            n_fail++; $display("FAIL wide_store_rsp: got cyc %0d err %b to %b %h want 3 0 0 %h", k, h_rsp_err, h_rsp_timeout, h_rsp_rdata, rd64);
        end
    endtask

    initial begin
        areset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0; arready = 0; rvalid = 0; rresp = '0; rdata = '0;
        h_req_valid = 0; h_req_write = 0; h_req_addr = '0; h_req_wdata = '0; h_req_wstrb = '0;
        h_bresp = '0; h_rresp = '0; h_rdata = '0;
        test_reset();
        test_store_zero_wait();
        test_store_w_before_aw();
        test_load_err();
        test_timeout();
        test_timeout_boundary();
        test_random();
        test_reset_midflight();
        test_wide_b2b();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
